// File: rtl/pipe_skid_pkg.sv
// Shared definitions for the valid/ready pipeline stages: occupancy state
// encoding, default payload width and the reset assertion level.
`ifndef PIPE_RST_ACTIVE
`define PIPE_RST_ACTIVE 1'b0
`endif

package pipe_skid_pkg;

  // Occupancy of a two-entry skid stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_DATA_W = 32;

endpackage

// File: rtl/pipe_skid_reg.sv
// Enable-gated payload register. Holds data only; no reset because the
// accompanying valid flops qualify its contents.
module pipe_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Capture the payload only when the owning entry is loaded.
  always_ff @(posedge clk) begin
    if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid.sv
// Two-entry skid buffer. Both handshake directions are registered:
// pout_valid comes from the main-entry valid flop and pin_ready from its own
// flop, so pout_ready never reaches pin_ready combinationally.
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pin_valid,
  output logic              pin_ready,
  input  logic [DATA_W-1:0] pin_data,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic [DATA_W-1:0] pout_data
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic              r_main_vld;
  logic              r_skid_vld;
  logic              r_pin_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_en;
  logic              w_skid_en;
  logic [DATA_W-1:0] w_main_d;
  logic [DATA_W-1:0] w_main_q;
  logic [DATA_W-1:0] w_skid_q;

  // Handshake events seen at the coming edge.
  always_comb begin
    w_in_fire  = pin_valid & r_pin_ready;
    w_out_fire = r_main_vld & pout_ready;
  end

  // Next occupancy; flush overrides everything, including a same-cycle input.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) w_state_nxt = ONE;
        ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = FULL;
          else if (!w_in_fire && w_out_fire) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_fire) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // State and handshake flops; valids/ready are decoded from the next state
  // so that every handshake output is a plain flop.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `PIPE_RST_ACTIVE) begin
      r_state     <= EMPTY;
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_pin_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main_vld  <= (w_state_nxt != EMPTY);
      r_skid_vld  <= (w_state_nxt == FULL);
      r_pin_ready <= (w_state_nxt != FULL);
    end
  end

  // Payload steering: main loads from input or from skid, skid catches the
  // one beat that arrives while main is stalled. Loads during a flush are
  // harmless because the valids clear.
  always_comb begin
    w_main_en = 1'b0;
    w_skid_en = 1'b0;
    w_main_d  = pin_data;
    case (r_state)
      EMPTY: w_main_en = w_in_fire;
      ONE: begin
        w_main_en = w_in_fire & w_out_fire;
        w_skid_en = w_in_fire & ~w_out_fire;
      end
      FULL: begin
        w_main_en = w_out_fire;
        w_main_d  = w_skid_q;
      end
      default: begin
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
      end
    endcase
  end

  pipe_reg #(.DATA_W(DATA_W)) u_main (
    .clk  (clk),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  pipe_reg #(.DATA_W(DATA_W)) u_skid (
    .clk  (clk),
    .i_en (w_skid_en),
    .i_d  (pin_data),
    .o_q  (w_skid_q)
  );

  assign pin_ready  = r_pin_ready;
  assign pout_valid = r_main_vld;
  assign pout_data  = w_main_q;

  // Skid is only ever occupied behind an occupied main entry.
  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (rst == `PIPE_RST_ACTIVE)
    !(r_skid_vld && !r_main_vld));

  // Ready flop always mirrors skid occupancy.
  a_ready_tracks_skid: assert property (
    @(posedge clk) disable iff (rst == `PIPE_RST_ACTIVE)
    r_pin_ready == !r_skid_vld);

  // Presented payload holds while the downstream stalls.
  a_stall_stable: assert property (
    @(posedge clk) disable iff (rst == `PIPE_RST_ACTIVE)
    (r_main_vld && !pout_ready && !flush) |=> $stable(w_main_q));

endmodule

// File: tb/tb_pipe_skid.sv
// Scoreboard bench for pipe_skid: accepted beats are queued by the stimulus
// side, the monitor checks presented beats, occupancy and ready against it.
module tb_pipe_skid;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush;
  logic         pin_valid;
  logic         pin_ready;
  logic [W-1:0] pin_data;
  logic         pout_valid;
  logic         pout_ready;
  logic [W-1:0] pout_data;

  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;

  pipe_skid #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pin_valid  (pin_valid),
    .pin_ready  (pin_ready),
    .pin_data   (pin_data),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .pout_data  (pout_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // One upstream cycle: drive at the falling edge, then record the beat in
  // the scoreboard if it is going to be accepted at the next rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, output bit acc);
    @(negedge clk);
    pin_valid  = v;
    pin_data   = d;
    pout_ready = r;
    flush      = f;
    #3;
    acc = (pin_valid === 1'b1) && (pin_ready === 1'b1) && (flush === 1'b0) && (rst === 1'b1);
    if (acc) exp_q.push_back(pin_data);
  endtask

  // Monitor: the model's occupancy is the queue length; main is its head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("pout_valid", {31'd0, pout_valid}, {31'd0, exp_q.size() != 0});
      chk("pin_ready", {31'd0, pin_ready}, {31'd0, exp_q.size() < 2});
      if (pout_valid === 1'b1 && exp_q.size() != 0) begin
        chk("pout_data", pout_data, exp_q[0]);
        if (pout_ready === 1'b1) void'(exp_q.pop_front());
      end
      if (flush === 1'b1) exp_q.delete();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    bit           have;
    logic [W-1:0] cur;
    int           beats;

    flush = 1'b0; pin_valid = 1'b0; pin_data = '0; pout_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_pout_valid", {31'd0, pout_valid}, 32'd0);
    chk("rst_pin_ready", {31'd0, pin_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0, acc);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, acc);

    // Stall: A enters, downstream stops, B goes to skid, C waits upstream.
    cycle(1'b1, 32'hA, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, acc);
    chk("stall_c_held", {31'd0, acc}, 32'd0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, acc);
    chk("stall_pin_ready", {31'd0, pin_ready}, 32'd0);
    while (!acc) cycle(1'b1, 32'hC, 1'b1, 1'b0, acc);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, acc);

    // Simultaneous in/out in ONE.
    cycle(1'b1, 32'h5, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h6, 1'b1, 1'b0, acc);
    chk("sim_in_accept", {31'd0, acc}, 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("sim_out_data", pout_data, 32'h6);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, acc);

    // Flush in FULL with a beat offered in the same cycle.
    cycle(1'b1, 32'h7, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h9, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    chk("flush_pout_valid", {31'd0, pout_valid}, 32'd0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-cycle while FULL.
    cycle(1'b1, 32'h11, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h12, 1'b0, 1'b0, acc);
    #1;
    exp_q.delete();
    pin_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_pout_valid", {31'd0, pout_valid}, 32'd0);
    chk("arst_pin_ready", {31'd0, pin_ready}, 32'd1);
    chk("arst_no_x", {31'd0, $isunknown({pout_valid, pin_ready})}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random valid/ready/flush traffic with upstream holding until accepted.
    have = 1'b0; cur = '0; beats = 0;
    while (beats < 10000) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        have = 1'b1;
        cur  = $urandom;
      end
      cycle(have, cur, $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0, acc);
      if (have && (acc || flush === 1'b1)) begin
        have = 1'b0;
        beats++;
      end
    end

    // Drain and confirm nothing is left behind.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
